// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - operand/product handshake bundle for seq_multiplier
interface seq_multiplier_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;
  logic               busy;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add WIDTH x WIDTH multiplier, signed/unsigned per operation
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  seq_multiplier_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  mag_a_q, mag_a_d;
  logic [WIDTH-1:0]  mag_b_q, mag_b_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     p_q, p_d;
  logic [CW-1:0]     count_q, count_d;
  logic              neg_q, neg_d;
  logic              in_ready_q, in_ready_d;
  logic [PW-1:0]     addend;
  logic [PW-1:0]     acc_sum;

  always_comb begin
    addend     = mag_b_q[0] ? ({{WIDTH{1'b0}}, mag_a_q} << count_q) : '0;
    acc_sum    = acc_q + addend;
    state_d    = state_q;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    acc_d      = acc_q;
    p_d        = p_q;
    count_d    = count_q;
    neg_d      = neg_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          mag_a_d = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
          mag_b_d = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
          neg_d   = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d   = '0;
          count_d = '0;
          if (bus.a == '0 || bus.b == '0) begin
            p_d     = '0;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d   = acc_sum;
        mag_b_d = mag_b_q >> 1;
        count_d = count_q + 1'b1;
        // Fixed latency: always WIDTH iterations, even when mag_b runs out early.
        if (count_q == CW'(WIDTH - 1)) begin
          p_d     = neg_q ? -acc_sum : acc_sum;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      acc_q      <= '0;
      p_q        <= '0;
      count_q    <= '0;
      neg_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      acc_q      <= acc_d;
      p_q        <= p_d;
      count_q    <= count_d;
      neg_q      <= neg_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.p         = p_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - directed self-checking bench for seq_multiplier at WIDTH 8 and 2
module tb_seq_multiplier;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_multiplier_if #(.WIDTH(8)) bus8 ();
  seq_multiplier_if #(.WIDTH(2)) bus2 ();

  seq_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  seq_multiplier #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic sm, input logic [15:0] pexp, input int lexp);
    int lat;
    lat = 0;
    while (bus8.in_ready !== 1'b1 && lat < 50) begin step(); lat++; end
    chk({tag, " in_ready before issue"}, 64'(bus8.in_ready), 64'd1);
    bus8.in_valid    = 1'b1;
    bus8.a           = av;
    bus8.b           = bv;
    bus8.signed_mode = sm;
    step();
    bus8.in_valid = 1'b0;
    bus8.a        = ~av;
    bus8.b        = ~bv;
    chk({tag, " busy after accept"}, 64'(bus8.busy), 64'd1);
    chk({tag, " in_ready after accept"}, 64'(bus8.in_ready), 64'd0);
    lat = 1;
    while (bus8.out_valid !== 1'b1 && lat < 50) begin step(); lat++; end
    chk({tag, " latency"}, 64'(lat), 64'(lexp));
    chk({tag, " p"}, 64'(bus8.p), 64'(pexp));
    bus8.out_ready = 1'b1;
    step();
    bus8.out_ready = 1'b0;
    chk({tag, " in_ready after handshake"}, 64'(bus8.in_ready), 64'd1);
    chk({tag, " out_valid after handshake"}, 64'(bus8.out_valid), 64'd0);
  endtask

  task automatic run2(input string tag, input logic [1:0] av, input logic [1:0] bv,
                      input logic sm, input logic [3:0] pexp, input int lexp);
    int lat;
    lat = 0;
    while (bus2.in_ready !== 1'b1 && lat < 20) begin step(); lat++; end
    bus2.in_valid    = 1'b1;
    bus2.a           = av;
    bus2.b           = bv;
    bus2.signed_mode = sm;
    step();
    bus2.in_valid = 1'b0;
    lat = 1;
    while (bus2.out_valid !== 1'b1 && lat < 20) begin step(); lat++; end
    chk({tag, " latency"}, 64'(lat), 64'(lexp));
    chk({tag, " p"}, 64'(bus2.p), 64'(pexp));
    bus2.out_ready = 1'b1;
    step();
    bus2.out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] held;
    logic        seen;
    int          pa;
    int          pb;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.signed_mode = 1'b0; bus8.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.signed_mode = 1'b0; bus2.out_ready = 1'b0;
    step();
    step();
    chk("reset in_ready", 64'(bus8.in_ready), 64'd0);
    chk("reset out_valid", 64'(bus8.out_valid), 64'd0);
    chk("reset busy", 64'(bus8.busy), 64'd0);
    chk("reset p", 64'(bus8.p), 64'd0);
    rst = 1'b0;
    step();
    chk("in_ready after reset release", 64'(bus8.in_ready), 64'd1);

    run8("u 255*255", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 9);
    run8("s 0x80*0x80", 8'h80, 8'h80, 1'b1, 16'h4000, 9);
    run8("s -3*5", 8'hFD, 8'h05, 1'b1, 16'hFFF1, 9);
    run8("s 127*-128", 8'h7F, 8'h80, 1'b1, 16'hC080, 9);
    run8("s -1*-1", 8'hFF, 8'hFF, 1'b1, 16'h0001, 9);
    run8("u 128*2", 8'h80, 8'h02, 1'b0, 16'h0100, 9);
    run8("u zero", 8'h00, 8'd200, 1'b0, 16'h0000, 1);
    run8("s zero", 8'h00, 8'd200, 1'b1, 16'h0000, 1);

    // Backpressure: product held while the producer side churns.
    bus8.in_valid = 1'b1; bus8.a = 8'h10; bus8.b = 8'h10; bus8.signed_mode = 1'b0;
    step();
    bus8.in_valid = 1'b0;
    repeat (8) step();
    chk("bp out_valid", 64'(bus8.out_valid), 64'd1);
    held = 16'h0100;
    for (int i = 0; i < 5; i++) begin
      bus8.in_valid = ~bus8.in_valid;
      bus8.a        = 8'($urandom);
      bus8.b        = 8'($urandom);
      step();
      chk("bp p stable", 64'(bus8.p), 64'(held));
      chk("bp in_ready low", 64'(bus8.in_ready), 64'd0);
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    step();
    bus8.out_ready = 1'b0;
    chk("bp in_ready after handshake", 64'(bus8.in_ready), 64'd1);
    chk("bp out_valid after handshake", 64'(bus8.out_valid), 64'd0);

    // Reset at count = 3 discards the operation.
    bus8.in_valid = 1'b1; bus8.a = 8'd100; bus8.b = 8'd100; bus8.signed_mode = 1'b0;
    step();
    bus8.in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("mid reset in_ready", 64'(bus8.in_ready), 64'd0);
    chk("mid reset out_valid", 64'(bus8.out_valid), 64'd0);
    chk("mid reset busy", 64'(bus8.busy), 64'd0);
    chk("mid reset p", 64'(bus8.p), 64'd0);
    rst = 1'b0;
    bus8.out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus8.out_valid === 1'b1) seen = 1'b1;
    end
    bus8.out_ready = 1'b0;
    chk("discarded op produced out_valid", 64'(seen), 64'd0);
    run8("u 12*11 after reset", 8'd12, 8'd11, 1'b0, 16'd132, 9);

    // WIDTH = 2 exhaustive against a small signed/unsigned model.
    for (int sm = 0; sm < 2; sm++) begin
      for (int ai = 0; ai < 4; ai++) begin
        for (int bi = 0; bi < 4; bi++) begin
          pa = (sm == 1 && ai >= 2) ? ai - 4 : ai;
          pb = (sm == 1 && bi >= 2) ? bi - 4 : bi;
          run2($sformatf("w2 sm=%0d %0d*%0d", sm, ai, bi), 2'(ai), 2'(bi), 1'(sm),
               4'((pa * pb) & 15), (ai == 0 || bi == 0) ? 1 : 3);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised iterative shift-add multiplier computing a WIDTH x WIDTH product into 2*WIDTH bits. It supports unsigned and two's-complement signed operands, selected per operation. Operands and results pass through valid/ready handshakes, so the block drops into streaming datapaths where area matters more than throughput. It is the sequential, area-minimal reference point alongside the combinational multipliers in our design-space exploration flow.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand set present on a, b and signed_mode.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_mode  input  1  0 = unsigned, 1 = two's-complement signed; sampled with a and b.
- out_valid  output  1  product on p is valid.
- out_ready  input  1  consumer accepts p.
- p  output  2*WIDTH  product; unsigned, or two's-complement when signed_mode was 1.
- busy  output  1  high in CALC or DONE.

## Operation
- One clock; reset is synchronous and active-high.
- The state machine has three states: IDLE, CALC and DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready, register the operands as follows.
  - Register mag_a = |a| and mag_b = |b| as WIDTH-bit unsigned values. The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and is representable.
  - Register neg = signed_mode & (a[MSB] ^ b[MSB]).
  - Clear the accumulator to 0 and the bit counter to 0.
  - Zero short-cut: if a == 0 or b == 0, go directly to DONE with p = 0. Otherwise go to CALC.
- CALC:
  - Each edge: if mag_b[0] is 1, acc += mag_a << count.
  - Each edge: mag_b >>= 1 and count += 1.
  - After WIDTH iterations, go to DONE. There is no early exit on a zero remaining mag_b; latency is fixed.
- DONE:
  - p = neg ? -acc : acc, computed mod 2^(2*WIDTH) and registered on entry.
  - out_valid = 1. p is held stable until the edge with out_valid & out_ready, then the block returns to IDLE.
  - in_valid is ignored outside IDLE; in_ready = 0 in CALC and DONE.
- Arithmetic:
  - The accumulator is 2*WIDTH bits wide; the unsigned magnitude product never overflows it.
  - The signed result always fits. Worst case (-2^(W-1))^2 = 2^(2W-2) < 2^(2W-1).
- Reset while rst = 1:
  - State forced to IDLE, in_ready = 0, out_valid = 0, busy = 0, p = 0, accumulator and counter cleared.
  - in_ready rises on the first cycle after rst deasserts.
  - Reset mid-CALC or mid-DONE discards the operation; no out_valid is ever produced for it.

## Timing
- Accept edge t0: the edge where in_valid & in_ready are both high.
- Normal operation: out_valid rises after edge t0 + WIDTH, i.e. WIDTH + 1 edges including the accept edge.
- Zero short-cut: out_valid rises after edge t0 itself, one edge after acceptance.
- in_ready is high in the cycle immediately after the output handshake edge. Back-to-back issue is therefore WIDTH + 2 cycles per product with out_ready held high.
- No operation overlap: one product is in flight at a time.
- All outputs are registered or decoded from the state register only. There are no combinational paths from in_valid or out_ready to any output.

## Test plan
- Unsigned max, WIDTH = 8, signed_mode = 0: a = 255, b = 255 -> p = 0xFE01, out_valid exactly 8 edges after acceptance.
- Signed corners, WIDTH = 8:
  - a = 0x80, b = 0x80 -> p = 0x4000.
  - a = 0xFD (-3), b = 0x05 -> p = 0xFFF1 (-15).
  - a = 0x7F, b = 0x80 -> p = 0xC080.
- Zero short-cut, either mode: a = 0, b = 200 -> p = 0, out_valid one edge after acceptance.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE while toggling in_valid and operands.
  - p stays stable and in_ready stays 0 throughout.
  - Handshake on the first out_ready = 1 edge; in_ready = 1 next cycle.
- Reset mid-CALC: assert rst at count = 3 for one cycle.
  - All outputs read 0 during reset, and no out_valid appears for the discarded operation.
  - The next operation, 12 * 11, returns 132.
- WIDTH = 2 exhaustive: all 16 (a, b) pairs in both modes, checked against a reference model, including signed -2 * -2 = 4 (p = 0x4).
